// File: rtl/convert_from_10.sv
// convert_from_10: accumulates a most-significant-first stream of decimal digits
// into a WIDTH-bit unsigned binary integer using a shift-add multiply by ten.
module convert_from_10 #(
    parameter int WIDTH      = 400,
    parameter int MAX_DIGITS = 120
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       digit_in,
    input  logic             digit_valid,
    input  logic             digit_last,
    output logic             ready,
    output logic [WIDTH-1:0] binary,
    output logic             done,
    output logic             overflow,
    output logic             error
);
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_DIGITS - 1);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] acc_q, acc_d, binary_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH+3:0] prod;
    logic             ready_q, done_q, overflow_q, error_q;
    logic             illegal, finish;

    // acc*10 + digit never exceeds WIDTH+4 bits, so the top nibble flags overflow
    always_comb begin
        prod    = ({4'b0, acc_q} << 3) + ({4'b0, acc_q} << 1) + {{WIDTH{1'b0}}, digit_in};
        illegal = digit_in > 4'd9;
        acc_d   = illegal ? acc_q : prod[WIDTH-1:0];
        finish  = digit_last || count_q == LAST_CNT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            count_q    <= '0;
            binary_q   <= '0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                state_q    <= ACCUM;
                acc_q      <= '0;
                count_q    <= '0;
                ready_q    <= 1'b1;
                overflow_q <= 1'b0;
                error_q    <= 1'b0;
            end else if (state_q == ACCUM && digit_valid) begin
                acc_q   <= acc_d;
                count_q <= count_q + 1'b1;
                if (illegal)
                    error_q <= 1'b1;
                else if (prod[WIDTH+3:WIDTH] != 4'd0)
                    overflow_q <= 1'b1;
                if (finish) begin
                    state_q  <= IDLE;
                    binary_q <= acc_d;
                    done_q   <= 1'b1;
                    ready_q  <= 1'b0;
                    if (!digit_last)
                        error_q <= 1'b1;
                end
            end
        end
    end

    assign ready    = ready_q;
    assign binary   = binary_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign error    = error_q;
endmodule

// File: tb/tb_convert_from_10.sv
// tb_convert_from_10: drives a full-size and a small (8-bit, 3-digit) instance with
// shared stimulus and checks both against an arithmetic reference model every cycle.
module tb_convert_from_10;
    localparam int MW[2] = '{400, 8};
    localparam int MD[2] = '{120, 3};

    logic clk = 1'b0;
    logic rst, start, digit_valid, digit_last;
    logic [3:0] digit_in;

    logic rdy0, done0, ovf0, err0, rdy1, done1, ovf1, err1;
    logic [399:0] bin0;
    logic [7:0]   bin1;

    int compared = 0;
    int mismatched = 0;

    bit [419:0] m_acc[2], m_bin[2];
    int         m_cnt[2];
    bit         m_act[2], m_done[2], m_ovf[2], m_err[2];

    always #5 clk = ~clk;

    convert_from_10 #(.WIDTH(400), .MAX_DIGITS(120)) u_big (
        .clk(clk), .rst(rst), .start(start), .digit_in(digit_in),
        .digit_valid(digit_valid), .digit_last(digit_last), .ready(rdy0),
        .binary(bin0), .done(done0), .overflow(ovf0), .error(err0)
    );

    convert_from_10 #(.WIDTH(8), .MAX_DIGITS(3)) u_small (
        .clk(clk), .rst(rst), .start(start), .digit_in(digit_in),
        .digit_valid(digit_valid), .digit_last(digit_last), .ready(rdy1),
        .binary(bin1), .done(done1), .overflow(ovf1), .error(err1)
    );

    task automatic chk(input string name, input logic [419:0] got, input logic [419:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Compare against the model state for the last edge, then advance the model
    // with the inputs that the next edge will sample.
    always @(negedge clk) begin
        logic [419:0] got_bin[2];
        logic         got[2][4];
        bit   [419:0] one, full;
        got_bin[0] = {20'b0, bin0};
        got_bin[1] = {412'b0, bin1};
        got[0] = '{rdy0, done0, ovf0, err0};
        got[1] = '{rdy1, done1, ovf1, err1};
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("ready%0d", i), {419'b0, got[i][0]}, {419'b0, m_act[i]});
            chk($sformatf("done%0d", i), {419'b0, got[i][1]}, {419'b0, m_done[i]});
            chk($sformatf("overflow%0d", i), {419'b0, got[i][2]}, {419'b0, m_ovf[i]});
            chk($sformatf("error%0d", i), {419'b0, got[i][3]}, {419'b0, m_err[i]});
            chk($sformatf("binary%0d", i), got_bin[i], m_bin[i]);
        end
        one = 1;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_acc[i] = 0; m_bin[i] = 0; m_cnt[i] = 0;
                m_act[i] = 0; m_done[i] = 0; m_ovf[i] = 0; m_err[i] = 0;
            end else begin
                m_done[i] = 0;
                if (start) begin
                    m_acc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0; m_err[i] = 0; m_act[i] = 1;
                end else if (m_act[i] && digit_valid) begin
                    m_cnt[i]++;
                    if (digit_in > 9) m_err[i] = 1;
                    else begin
                        full = m_acc[i] * 10 + digit_in;
                        if ((full >> MW[i]) != 0) m_ovf[i] = 1;
                        m_acc[i] = full & ((one << MW[i]) - 1);
                    end
                    if (digit_last || m_cnt[i] == MD[i]) begin
                        m_bin[i] = m_acc[i];
                        m_done[i] = 1;
                        m_act[i] = 0;
                        if (!digit_last) m_err[i] = 1;
                    end
                end
            end
        end
    end

    task automatic drive(input logic r, input logic s, input logic v, input logic l, input logic [3:0] d);
        rst = r; start = s; digit_valid = v; digit_last = l; digit_in = d;
        @(posedge clk);
        #2;
    endtask

    task automatic st();
        drive(0, 1, 0, 0, 4'd0);
    endtask

    task automatic dg(input logic [3:0] d, input logic l);
        drive(0, 0, 1, l, d);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 4'd0);
    endtask

    initial begin
        rst = 1; start = 0; digit_valid = 0; digit_last = 0; digit_in = 0;
        repeat (3) drive(1, 0, 0, 0, 4'd0);
        chk("reset_ready", {419'b0, rdy0}, 0);
        chk("reset_binary", {20'b0, bin0}, 0);
        idle();

        st(); dg(1, 0); dg(2, 0); dg(3, 1);
        chk("t1_done", {419'b0, done0}, 1);
        chk("t1_bin", {20'b0, bin0}, 123);
        chk("t1_small_bin", {412'b0, bin1}, 123);
        chk("t1_flags", {418'b0, ovf0, err0}, 0);
        idle();
        chk("t1_done_low", {419'b0, done0}, 0);
        chk("t1_ready_low", {419'b0, rdy0}, 0);

        st(); dg(2, 0); dg(5, 0); dg(5, 1);
        chk("t2_255", {412'b0, bin1}, 255);
        chk("t2_255_ovf", {419'b0, ovf1}, 0);
        st(); dg(2, 0); dg(5, 0); dg(6, 1);
        chk("t2_256_small", {412'b0, bin1}, 0);
        chk("t2_256_ovf", {419'b0, ovf1}, 1);
        chk("t2_256_big", {20'b0, bin0}, 256);
        st();
        chk("t2_ovf_cleared", {419'b0, ovf1}, 0);
        chk("t2_bin_held", {412'b0, bin1}, 0);
        dg(7, 1);
        chk("t2_7", {412'b0, bin1}, 7);

        st(); dg(4, 0); dg(4'hA, 0); dg(2, 1);
        chk("t3_bin", {20'b0, bin0}, 42);
        chk("t3_err", {419'b0, err0}, 1);
        st(); dg(4, 0); repeat (3) idle(); dg(4'hA, 0); repeat (3) idle(); dg(2, 1);
        chk("t3_gap_bin", {20'b0, bin0}, 42);
        chk("t3_gap_err", {419'b0, err0}, 1);

        st(); dg(1, 0); dg(2, 0); dg(3, 0);
        chk("t4_small_done", {419'b0, done1}, 1);
        chk("t4_small_bin", {412'b0, bin1}, 123);
        chk("t4_small_err", {419'b0, err1}, 1);
        chk("t4_big_busy", {418'b0, rdy0, done0}, 2);
        dg(4, 0);
        chk("t4_small_ignored", {411'b0, done1, bin1}, 123);
        dg(5, 1);
        chk("t4_big_bin", {20'b0, bin0}, 12345);

        st(); dg(9, 0); dg(9, 0); drive(0, 1, 1, 0, 4'd5);
        chk("t5_abort", {418'b0, rdy0, done0}, 2);
        dg(7, 1);
        chk("t5_bin", {20'b0, bin0}, 7);
        chk("t5_done", {419'b0, done0}, 1);
        idle();
        chk("t5_done_once", {419'b0, done0}, 0);

        st(); dg(8, 0); dg(8, 0); drive(1, 0, 0, 0, 4'd0);
        chk("t6_rst", {20'b0, bin0}, 0);
        chk("t6_rst_ctl", {418'b0, rdy0, done0}, 0);
        dg(3, 1);
        chk("t6_no_done", {419'b0, done0}, 0);
        chk("t6_bin_zero", {20'b0, bin0}, 0);

        st(); repeat (119) dg(9, 0);
        chk("t7_not_yet", {418'b0, rdy0, done0}, 2);
        dg(9, 0);
        chk("t7_limit_done", {419'b0, done0}, 1);
        chk("t7_limit_err", {419'b0, err0}, 1);
        idle();

        for (int n = 0; n < 15000; n++) begin
            int r;
            logic [3:0] d;
            r = int'($urandom_range(999));
            d = ($urandom_range(15) == 0) ? 4'($urandom_range(15, 10)) : 4'($urandom_range(9));
            drive(r < 2, r >= 2 && r < 7, $urandom_range(9) < 6, $urandom_range(249) == 0, d);
        end
        idle(); idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/convert_from_10.md
Name: convert_from_10

Overview:
- Inverse of the team's serial binary-to-decimal digit streamer: accepts a stream of decimal digits, most significant first, and accumulates them into a WIDTH-bit unsigned binary integer.
- Per accepted digit: acc = acc*10 + digit, computed with a shift-add (acc<<3)+(acc<<1)+digit. No multiplier.
- Sits between the digit source (UART/keypad/BCD front end) and the wide binary arithmetic datapath.

Parameters:
- WIDTH, 400, binary result width in bits.
- MAX_DIGITS, 120, maximum digits accepted per conversion. 120 = floor(400*log10(2)), the largest count guaranteed to fit in 400 bits.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin new conversion; clears accumulator and flags
- digit_in  input  4  decimal digit, 0-9 legal
- digit_valid  input  1  digit_in valid this cycle
- digit_last  input  1  qualifies digit_in as final digit; only meaningful with digit_valid
- ready  output  1  block accepting digits
- binary  output  WIDTH  converted result; updated only at completion, held until the next completion
- done  output  1  one-cycle pulse when binary is updated
- overflow  output  1  sticky: result exceeded 2^WIDTH-1; binary holds the low WIDTH bits
- error  output  1  sticky: illegal digit seen, or MAX_DIGITS reached without digit_last

Behaviour:
- Reset (rst=1 at edge, any state): state IDLE; binary=0, ready=0, done=0, overflow=0, error=0; internal acc=0, count=0. rst overrides start and digit_valid.
- States: IDLE, ACCUM.
- IDLE:
  - ready=0, done=0 after its pulse; digit_valid ignored.
  - start: acc<=0, count<=0, overflow<=0, error<=0, state<=ACCUM, ready<=1. binary is not cleared.
- ACCUM:
  - ready=1; a digit is accepted at an edge where digit_valid=1 and ready=1.
  - Arithmetic: next = acc*10 + digit_in evaluated at WIDTH+4 bits. acc<=next[WIDTH-1:0]. If next[WIDTH+3:WIDTH] != 0, set overflow (sticky).
  - Illegal digit (digit_in>9): error<=1; acc unchanged; count still increments; digit_last is still honoured.
  - count increments on every accepted digit.
  - Termination: accepted digit with digit_last=1, or accepted digit when count==MAX_DIGITS-1 (in that case error<=1 if digit_last=0). At that edge: binary<=updated acc, done<=1, ready<=0, state<=IDLE.
- Latency: done and the new binary are visible the cycle after the edge that accepts the last digit. done is high exactly one cycle. Back-to-back: start may be asserted in the cycle done is high.
- Priority: rst > start > digit_valid. start in ACCUM aborts the current conversion: acc/count/flags cleared, stay ACCUM, no done, binary unchanged; any digit in that same cycle is discarded.
- digit_last without digit_valid: ignored.
- overflow and error hold their values after done until the next start or rst.

Test Plan:
- start; digits 1,2,3 (last on 3), one per cycle -> done pulses once, cycle after the digit 3 edge; binary=123; overflow=0; error=0; ready=0 afterwards.
- WIDTH=8 instance: digits 2,5,5 last -> binary=255, overflow=0. Then start; digits 2,5,6 last -> binary=0, overflow=1. Then start; digit 7 last -> binary=7, overflow=0 (cleared by start).
- start; digits 4, 0xA, 2 last -> binary=42, error=1. Gaps of 3 idle cycles (digit_valid=0) between digits -> same result.
- MAX_DIGITS=3: start; digits 1,2,3,4, digit_last never set -> termination after 3, binary=123, error=1; digit 4 ignored (ready=0).
- start; digits 9,9; start again with digit_valid=1 and digit 5 in that same cycle; then 7 last -> binary=7, exactly one done pulse.
- start; digits 8,8; rst for one cycle -> binary=0, ready=0, no done. Following digit_valid=1 with 3 last and no start -> no done, binary stays 0.
